// File: rtl/apb_sram_arb.sv
// apb_sram_arb: two-client round-robin APB4 master in front of one apb_sram.
// Optional macro APB_ARB_TIMEOUT_EN: abort ACCESS after TIMEOUT_CYC wait states.
//
// Ports:
//   pclk_i, prst_n_i       clock, async active-low reset
//   cN_req_i .. cN_wdata_i client N command (held until cN_ack_o)
//   cN_ack_o/rdata_o/err_o one-cycle completion with read data / error
//   psel_o .. pwdata_o     registered APB request
//   pready_i/prdata_i/pslverr_i  APB response
module apb_sram_arb #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                    pclk_i,
    input  logic                    prst_n_i,
    input  logic                    c0_req_i,
    input  logic                    c0_write_i,
    input  logic [ADDR_WIDTH-1:0]   c0_addr_i,
    input  logic [DATA_WIDTH/8-1:0] c0_strb_i,
    input  logic [DATA_WIDTH-1:0]   c0_wdata_i,
    output logic                    c0_ack_o,
    output logic [DATA_WIDTH-1:0]   c0_rdata_o,
    output logic                    c0_err_o,
    input  logic                    c1_req_i,
    input  logic                    c1_write_i,
    input  logic [ADDR_WIDTH-1:0]   c1_addr_i,
    input  logic [DATA_WIDTH/8-1:0] c1_strb_i,
    input  logic [DATA_WIDTH-1:0]   c1_wdata_i,
    output logic                    c1_ack_o,
    output logic [DATA_WIDTH-1:0]   c1_rdata_o,
    output logic                    c1_err_o,
    output logic                    psel_o,
    output logic                    penable_o,
    output logic [ADDR_WIDTH-1:0]   paddr_o,
    output logic                    pwrite_o,
    output logic [DATA_WIDTH/8-1:0] pstrb_o,
    output logic [DATA_WIDTH-1:0]   pwdata_o,
    input  logic                    pready_i,
    input  logic [DATA_WIDTH-1:0]   prdata_i,
    input  logic                    pslverr_i
);

    localparam int SW = DATA_WIDTH / 8;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    logic [1:0]            state_q;
    logic                  prio_q;
    logic                  gnt_q;
    logic [1:0]            ack_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic [1:0] req;
    logic [1:0] elig;
    logic       win;
    logic       timeout;
    logic       complete;

    // A client being acked this cycle is masked so its held req
    // does not immediately re-issue the same command.
    assign req  = {c1_req_i, c0_req_i};
    assign elig = req & ~ack_q;
    assign win  = (elig == 2'b11) ? prio_q : elig[1];

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] wcnt_q;

    assign timeout = (state_q == S_ACCESS) && !pready_i &&
                     (wcnt_q == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge pclk_i or negedge prst_n_i) begin
        if (!prst_n_i) begin
            wcnt_q <= '0;
        end else if (state_q == S_SETUP) begin
            wcnt_q <= '0;
        end else if (state_q == S_ACCESS && !pready_i && !timeout) begin
            wcnt_q <= wcnt_q + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign complete = (state_q == S_ACCESS) && (pready_i || timeout);

    always_ff @(posedge pclk_i or negedge prst_n_i) begin
        if (!prst_n_i) begin
            state_q   <= S_IDLE;
            prio_q    <= 1'b0;
            gnt_q     <= 1'b0;
            ack_q     <= 2'b00;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            paddr_o   <= '0;
            pwrite_o  <= 1'b0;
            pstrb_o   <= '0;
            pwdata_o  <= '0;
        end else begin
            ack_q <= 2'b00;
            case (state_q)
                S_IDLE: begin
                    if (|elig) begin
                        gnt_q     <= win;
                        prio_q    <= ~win;
                        psel_o    <= 1'b1;
                        penable_o <= 1'b0;
                        state_q   <= S_SETUP;
                        if (win) begin
                            paddr_o  <= c1_addr_i;
                            pwrite_o <= c1_write_i;
                            pstrb_o  <= c1_write_i ? c1_strb_i : SW'(0);
                            pwdata_o <= c1_wdata_i;
                        end else begin
                            paddr_o  <= c0_addr_i;
                            pwrite_o <= c0_write_i;
                            pstrb_o  <= c0_write_i ? c0_strb_i : SW'(0);
                            pwdata_o <= c0_wdata_i;
                        end
                    end
                end
                S_SETUP: begin
                    penable_o <= 1'b1;
                    state_q   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (complete) begin
                        psel_o    <= 1'b0;
                        penable_o <= 1'b0;
                        state_q   <= S_IDLE;
                        ack_q     <= gnt_q ? 2'b10 : 2'b01;
                        rdata_q   <= (timeout || pwrite_o) ? '0 : prdata_i;
                        err_q     <= timeout | pslverr_i;
                    end
                end
                default: begin
                    psel_o    <= 1'b0;
                    penable_o <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    // Response data is shared; each client only sees it during its ack.
    assign c0_ack_o   = ack_q[0];
    assign c1_ack_o   = ack_q[1];
    assign c0_rdata_o = ack_q[0] ? rdata_q : '0;
    assign c1_rdata_o = ack_q[1] ? rdata_q : '0;
    assign c0_err_o   = ack_q[0] & err_q;
    assign c1_err_o   = ack_q[1] & err_q;

endmodule

// File: tb/tb_apb_sram_arb.sv
// tb_apb_sram_arb: directed bench for apb_sram_arb with a small APB SRAM model.
// Define APB_ARB_TIMEOUT_EN for both files to exercise the timeout build.
module tb_apb_sram_arb;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          c0_req = 0, c0_write = 0, c1_req = 0, c1_write = 0;
    logic [AW-1:0] c0_addr = '0, c1_addr = '0;
    logic [SW-1:0] c0_strb = '0, c1_strb = '0;
    logic [DW-1:0] c0_wdata = '0, c1_wdata = '0;
    logic          c0_ack, c1_ack, c0_err, c1_err;
    logic [DW-1:0] c0_rdata, c1_rdata;
    logic          psel, penable, pwrite, pready, pslverr;
    logic [AW-1:0] paddr;
    logic [SW-1:0] pstrb;
    logic [DW-1:0] pwdata, prdata;

    int vecs = 0;
    int errs = 0;

    logic [DW-1:0] mem [0:1023];
    int   ws = 0;
    int   nwait = 0;
    logic stall = 1'b0;
    logic err_inj = 1'b0;

    always #5 clk = ~clk;

    apb_sram_arb #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT_CYC(16)
    ) dut (
        .pclk_i    (clk),
        .prst_n_i  (rst_n),
        .c0_req_i  (c0_req),
        .c0_write_i(c0_write),
        .c0_addr_i (c0_addr),
        .c0_strb_i (c0_strb),
        .c0_wdata_i(c0_wdata),
        .c0_ack_o  (c0_ack),
        .c0_rdata_o(c0_rdata),
        .c0_err_o  (c0_err),
        .c1_req_i  (c1_req),
        .c1_write_i(c1_write),
        .c1_addr_i (c1_addr),
        .c1_strb_i (c1_strb),
        .c1_wdata_i(c1_wdata),
        .c1_ack_o  (c1_ack),
        .c1_rdata_o(c1_rdata),
        .c1_err_o  (c1_err),
        .psel_o    (psel),
        .penable_o (penable),
        .paddr_o   (paddr),
        .pwrite_o  (pwrite),
        .pstrb_o   (pstrb),
        .pwdata_o  (pwdata),
        .pready_i  (pready),
        .prdata_i  (prdata),
        .pslverr_i (pslverr)
    );

    // APB SRAM model: nwait wait states, stall forces pready low.
    assign pready  = psel & penable & ~stall & (ws >= nwait);
    assign prdata  = mem[paddr[11:2]];
    assign pslverr = err_inj;

    always @(posedge clk) begin
        if (psel && penable && !pready) ws <= ws + 1;
        else ws <= 0;
        if (psel && penable && pready && pwrite)
            for (int b = 0; b < SW; b++)
                if (pstrb[b]) mem[paddr[11:2]][8*b +: 8] <= pwdata[8*b +: 8];
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic c0_cmd(input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
        c0_write = w; c0_addr = a; c0_wdata = d; c0_strb = 4'hF; c0_req = 1'b1;
    endtask

    task automatic c1_cmd(input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
        c1_write = w; c1_addr = a; c1_wdata = d; c1_strb = 4'hF; c1_req = 1'b1;
    endtask

    initial begin
        int n0, n1, w;
        // Reset values
        #1;
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwrite", pwrite, 0);
        check("rst_pstrb", pstrb, 0);
        check("rst_pwdata", pwdata, 0);
        check("rst_c0_ack", c0_ack, 0);
        check("rst_c1_ack", c1_ack, 0);
        step(); step();
        rst_n = 1'b1;
        step();

        // 1: c0 write then read back
        c0_cmd(1'b1, 12'h010, 32'hA5A5_0001);
        step();
        check("t1_setup_psel", psel, 1);
        check("t1_setup_pen", penable, 0);
        check("t1_paddr", paddr, 12'h010);
        check("t1_pwrite", pwrite, 1);
        check("t1_pstrb", pstrb, 4'hF);
        check("t1_pwdata", pwdata, 32'hA5A5_0001);
        step();
        check("t1_access_pen", penable, 1);
        step();
        check("t1_ack", c0_ack, 1);
        check("t1_err", c0_err, 0);
        check("t1_psel_drop", psel, 0);
        c0_req = 1'b0;
        step();
        check("t1_ack_1cyc", c0_ack, 0);
        c0_cmd(1'b0, 12'h010, 32'h0);
        step();
        check("t1r_pwrite", pwrite, 0);
        step(); step();
        check("t1r_ack", c0_ack, 1);
        check("t1r_rdata", c0_rdata, 32'hA5A5_0001);
        c0_req = 1'b0;
        step();

        // 2: both clients, 4 writes each, round-robin from reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n0 = 0; n1 = 0;
        c0_cmd(1'b1, 12'h100, 32'hC000_0000);
        c1_cmd(1'b1, 12'h200, 32'hC100_0000);
        for (int t = 0; t < 8; t++) begin
            w = 1;
            step();
            while (!(c0_ack || c1_ack) && w < 10) begin
                step();
                w++;
            end
            check("t2_who", c1_ack, (t % 2));
            check("t2_gap", w, 3);
            if (c0_ack) begin
                n0++;
                if (n0 == 4) c0_req = 1'b0;
                else c0_cmd(1'b1, 12'h100 + AW'(4 * n0), 32'hC000_0000 + n0);
            end
            if (c1_ack) begin
                n1++;
                if (n1 == 4) c1_req = 1'b0;
                else c1_cmd(1'b1, 12'h200 + AW'(4 * n1), 32'hC100_0000 + n1);
            end
        end
        check("t2_mem_c0", mem[12'h10C >> 2], 32'hC000_0003);
        check("t2_mem_c1", mem[12'h20C >> 2], 32'hC100_0003);
        step();

        // 3: c1 read with 3 wait states
        c1_cmd(1'b0, 12'h204, 32'h0);
        nwait = 3;
        step();
        check("t3_setup_pen", penable, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t3_pen", penable, 1);
            check("t3_paddr", paddr, 12'h204);
            check("t3_noack", c1_ack, 0);
        end
        step();
        check("t3_ack", c1_ack, 1);
        check("t3_rdata", c1_rdata, 32'hC100_0001);
        c1_req = 1'b0;
        nwait = 0;
        step();

        // 4: read with slave error; strobes stay 0
        c0_cmd(1'b0, 12'h010, 32'h0);
        err_inj = 1'b1;
        step();
        check("t4_pstrb_setup", pstrb, 0);
        step();
        check("t4_pstrb_access", pstrb, 0);
        step();
        check("t4_ack", c0_ack, 1);
        check("t4_err", c0_err, 1);
        c0_req = 1'b0;
        err_inj = 1'b0;
        step();
        check("t4_err_clear", c0_err, 0);

        // 5: reset during ACCESS of a c0 write
        c0_cmd(1'b1, 12'h300, 32'h5555_5555);
        nwait = 5;
        step(); step();
        check("t5_in_access", penable, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_psel", psel, 0);
        check("t5_penable", penable, 0);
        check("t5_paddr", paddr, 0);
        check("t5_pwdata", pwdata, 0);
        check("t5_pstrb", pstrb, 0);
        c0_req = 1'b0;
        step();
        check("t5_noack_rst", c0_ack, 0);
        rst_n = 1'b1;
        nwait = 0;
        step();
        check("t5_noack_after", c0_ack, 0);
        check("t5_idle", psel, 0);
        c0_cmd(1'b0, 12'h010, 32'h0);
        c1_cmd(1'b0, 12'h204, 32'h0);
        step();
        check("t5_prio_c0", paddr, 12'h010);
        step(); step();
        check("t5_c0_ack", c0_ack, 1);
        check("t5_c0_rdata", c0_rdata, 32'hA5A5_0001);
        c0_req = 1'b0;
        step();
        check("t5_c1_next", paddr, 12'h204);
        step(); step();
        check("t5_c1_ack", c1_ack, 1);
        check("t5_c1_rdata", c1_rdata, 32'hC100_0001);
        c1_req = 1'b0;
        step();

        // 6: slave never ready
        c0_cmd(1'b0, 12'h010, 32'h0);
        stall = 1'b1;
        step(); step();
        w = 0;
        while (!c0_ack && w < 40) begin
            step();
            w++;
        end
`ifdef APB_ARB_TIMEOUT_EN
        check("t6_to_cycles", w, 16);
        check("t6_to_ack", c0_ack, 1);
        check("t6_to_err", c0_err, 1);
        check("t6_to_rdata", c0_rdata, 0);
        c0_req = 1'b0;
        stall = 1'b0;
`else
        check("t6_wait_bound", w, 40);
        check("t6_psel_held", psel, 1);
        check("t6_pen_held", penable, 1);
        stall = 1'b0;
        step();
        check("t6_late_ack", c0_ack, 1);
        check("t6_late_rdata", c0_rdata, 32'hA5A5_0001);
        c0_req = 1'b0;
`endif
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
